hazard_ctrl: RTL and testbench

// - Control end of the ID/EX hazard interface: consumes ID source regs and EX/MEM/WB destination info, drives pipeline stall/bubble/flush/freeze.
// - Detects load-use (and, with FWD=0, any RAW) hazards; holds IF/ID, injects ID/EX bubbles for a counted number of cycles.
// - Also handles EX branch-taken flush and global freeze on data-memory wait. Sits beside the 5-stage pipeline; one instance per core.

---
 rtl/hazard_ctrl_pkg.sv | 17 +
 rtl/hazard_ctrl_match.sv | 13 +
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the ID/EX hazard controller: destination descriptors and FSM states.
package hazard_ctrl_pkg;

  localparam logic [4:0] HZ_X0 = 5'd0;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [4:0] rd;
  } hz_dst_t;

  typedef enum logic {
    IDLE,
    HOLD
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_match.sv
// One source-vs-destination RAW comparator; x0 and unused sources never hit.
module hz_match
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       used,
  input  hz_dst_t    dst,
  output logic       hit
);

  assign hit = used && (rs != HZ_X0) && dst.valid && dst.reg_write && (rs == dst.rd);

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX hazard control: load-use / RAW stall with counted bubbles, branch flush, memory-wait freeze.
// All outputs are combinational from inputs and state; state advances on posedge clk.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter bit FWD             = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_valid,
  input  logic       ex_load,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_branch_taken,
  input  logic       mem_wait,
  output logic       stall,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic       freeze
);

  // First cycle is spent in IDLE, so HOLD covers the remaining LOAD_USE_CYCLES-1.
  localparam logic [2:0] CNT_INIT = (LOAD_USE_CYCLES > 1) ? 3'(LOAD_USE_CYCLES - 2) : 3'd0;

  hz_state_e state_q;
  logic [2:0] cnt_q;
  hz_dst_t    mem_q;
  hz_dst_t    wb_q;
  hz_dst_t    ex_dst;
  logic       ex_hit1;
  logic       ex_hit2;
  logic       lu_hit;
  logic       raw_hit;

  assign ex_dst = '{valid: ex_valid, reg_write: ex_reg_write, rd: ex_rd_addr};

  hz_match u_ex_rs1 (.rs(id_rs1_addr), .used(id_rs1_used), .dst(ex_dst), .hit(ex_hit1));
  hz_match u_ex_rs2 (.rs(id_rs2_addr), .used(id_rs2_used), .dst(ex_dst), .hit(ex_hit2));

  assign lu_hit = ex_load && (ex_hit1 || ex_hit2);

  generate
    if (FWD == 1'b0) begin : g_raw
      logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;
      hz_match u_mem_rs1 (.rs(id_rs1_addr), .used(id_rs1_used), .dst(mem_q), .hit(mem_hit1));
      hz_match u_mem_rs2 (.rs(id_rs2_addr), .used(id_rs2_used), .dst(mem_q), .hit(mem_hit2));
      hz_match u_wb_rs1  (.rs(id_rs1_addr), .used(id_rs1_used), .dst(wb_q),  .hit(wb_hit1));
      hz_match u_wb_rs2  (.rs(id_rs2_addr), .used(id_rs2_used), .dst(wb_q),  .hit(wb_hit2));
      assign raw_hit = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2 || wb_hit1 || wb_hit2;
    end else begin : g_fwd
      // Forwarding covers everything but load-use; the shadows go unobserved here.
      logic unused_shadow;
      assign unused_shadow = ^{mem_q, wb_q};
      assign raw_hit       = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else if (!mem_wait) begin
      mem_q <= ex_dst;
      wb_q  <= mem_q;
      if (ex_branch_taken) begin
        state_q <= IDLE;
        cnt_q   <= 3'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (lu_hit && (LOAD_USE_CYCLES > 1)) begin
              state_q <= HOLD;
              cnt_q   <= CNT_INIT;
            end
          end
          HOLD: begin
            if (cnt_q == 3'd0) state_q <= IDLE;
            else               cnt_q   <= cnt_q - 3'd1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    stall     = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    freeze    = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else if (mem_wait) begin
      freeze = 1'b1;
      stall  = 1'b1;
    end else if (ex_branch_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if ((state_q == HOLD) || lu_hit || raw_hit) begin
      stall     = 1'b1;
      bubble_ex = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl across L=1/FWD=1, L=3/FWD=1, L=1/FWD=0 and L=4/FWD=1 instances.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_rs1_used, id_rs2_used;
  logic       ex_valid, ex_load, ex_reg_write, ex_branch_taken, mem_wait;
  // Output nibbles: {freeze, flush_id, bubble_ex, stall}
  logic [3:0] o_a, o_b, o_c, o_d;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_USE_CYCLES(1), .FWD(1'b1)) dut_a (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_load(ex_load), .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .stall(o_a[0]), .bubble_ex(o_a[1]), .flush_id(o_a[2]), .freeze(o_a[3]));

  hazard_ctrl #(.LOAD_USE_CYCLES(3), .FWD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_load(ex_load), .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .stall(o_b[0]), .bubble_ex(o_b[1]), .flush_id(o_b[2]), .freeze(o_b[3]));

  hazard_ctrl #(.LOAD_USE_CYCLES(1), .FWD(1'b0)) dut_c (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_load(ex_load), .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .stall(o_c[0]), .bubble_ex(o_c[1]), .flush_id(o_c[2]), .freeze(o_c[3]));

  hazard_ctrl #(.LOAD_USE_CYCLES(4), .FWD(1'b1)) dut_d (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_load(ex_load), .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .stall(o_d[0]), .bubble_ex(o_d[1]), .flush_id(o_d[2]), .freeze(o_d[3]));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic ld, input logic rw, input logic [4:0] rd);
    ex_valid     = v;
    ex_load      = ld;
    ex_reg_write = rw;
    ex_rd_addr   = rd;
  endtask

  task automatic set_id(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    id_rs1_addr = r1;
    id_rs1_used = u1;
    id_rs2_addr = r2;
    id_rs2_used = u2;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    mem_wait        = 1'b0;
    ex_branch_taken = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 5'd0);
    set_id(5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Outputs forced low while in reset, even with freeze and hazard inputs active
    rst = 1'b1; mem_wait = 1'b1; ex_branch_taken = 1'b0;
    set_ex(1'b1, 1'b1, 1'b1, 5'd5);
    set_id(5'd5, 1'b1, 5'd1, 1'b1);
    #2;
    chk("rst_a", o_a, 4'b0000);
    chk("rst_b", o_b, 4'b0000);
    chk("rst_c", o_c, 4'b0000);
    do_reset();

    // lw x5 in EX, add x6,x5,x1 in ID
    set_ex(1'b1, 1'b1, 1'b1, 5'd5);
    set_id(5'd5, 1'b1, 5'd1, 1'b1);
    #1;
    chk("lu1_c0_a", o_a, 4'b0011);
    chk("lu3_c0_b", o_b, 4'b0011);
    tick(); set_ex(1'b0, 1'b0, 1'b0, 5'd0); #1;
    chk("lu1_c1_a", o_a, 4'b0000);
    chk("lu3_c1_b", o_b, 4'b0011);
    tick(); mem_wait = 1'b1; #1;
    chk("lu3_wait1_b", o_b, 4'b1001);
    chk("wait_a", o_a, 4'b1001);
    tick(); #1;
    chk("lu3_wait2_b", o_b, 4'b1001);
    tick(); mem_wait = 1'b0; #1;
    chk("lu3_c2_b", o_b, 4'b0011);
    tick(); #1;
    chk("lu3_done_b", o_b, 4'b0000);

    // Back-to-back loads on the L=3 instance
    set_ex(1'b1, 1'b1, 1'b1, 5'd6); set_id(5'd6, 1'b1, 5'd0, 1'b0); #1;
    chk("b2b_c0_b", o_b, 4'b0011);
    tick(); set_ex(1'b0, 1'b0, 1'b0, 5'd0); #1;
    chk("b2b_c1_b", o_b, 4'b0011);
    tick(); #1;
    chk("b2b_c2_b", o_b, 4'b0011);
    tick(); set_ex(1'b1, 1'b1, 1'b1, 5'd7); set_id(5'd0, 1'b0, 5'd7, 1'b1); #1;
    chk("b2b_c3_b", o_b, 4'b0011);
    tick(); set_ex(1'b0, 1'b0, 1'b0, 5'd0); #1;
    chk("b2b_c4_b", o_b, 4'b0011);
    tick(); #1;
    chk("b2b_c5_b", o_b, 4'b0011);
    tick(); #1;
    chk("b2b_c6_b", o_b, 4'b0000);

    // No-hazard cases
    do_reset();
    set_ex(1'b1, 1'b1, 1'b1, 5'd0); set_id(5'd0, 1'b1, 5'd0, 1'b1); #1;
    chk("x0_a", o_a, 4'b0000);
    set_ex(1'b1, 1'b1, 1'b1, 5'd9); set_id(5'd3, 1'b1, 5'd9, 1'b0); #1;
    chk("rs2_unused_a", o_a, 4'b0000);
    set_ex(1'b0, 1'b1, 1'b1, 5'd5); set_id(5'd5, 1'b1, 5'd0, 1'b0); #1;
    chk("ex_invalid_a", o_a, 4'b0000);

    // addi x3 in EX, ID reads x3: forwarded at FWD=1, three-cycle stall at FWD=0
    set_ex(1'b1, 1'b0, 1'b1, 5'd3); set_id(5'd3, 1'b1, 5'd0, 1'b0); #1;
    chk("alu_fwd_a", o_a, 4'b0000);
    chk("raw_ex_c", o_c, 4'b0011);
    tick(); set_ex(1'b0, 1'b0, 1'b0, 5'd0); #1;
    chk("raw_mem_c", o_c, 4'b0011);
    chk("raw_mem_a", o_a, 4'b0000);
    tick(); #1;
    chk("raw_wb_c", o_c, 4'b0011);
    tick(); #1;
    chk("raw_done_c", o_c, 4'b0000);

    // Branch during HOLD, with freeze taking priority first
    do_reset();
    set_ex(1'b1, 1'b1, 1'b1, 5'd5); set_id(5'd5, 1'b1, 5'd1, 1'b1); #1;
    chk("br_c0_b", o_b, 4'b0011);
    tick(); set_ex(1'b0, 1'b0, 1'b0, 5'd0); ex_branch_taken = 1'b1; mem_wait = 1'b1; #1;
    chk("br_freeze_b", o_b, 4'b1001);
    tick(); mem_wait = 1'b0; #1;
    chk("br_flush_b", o_b, 4'b0110);
    tick(); ex_branch_taken = 1'b0; set_id(5'd0, 1'b0, 5'd0, 1'b0); #1;
    chk("br_after_b", o_b, 4'b0000);

    // Async reset while HOLD with cnt=2
    do_reset();
    set_ex(1'b1, 1'b1, 1'b1, 5'd5); set_id(5'd5, 1'b1, 5'd1, 1'b1); #1;
    chk("rh_c0_d", o_d, 4'b0011);
    tick(); set_ex(1'b0, 1'b0, 1'b0, 5'd0); #1;
    chk("rh_c1_d", o_d, 4'b0011);
    #1 rst = 1'b1; #1;
    chk("rh_rst_d", o_d, 4'b0000);
    tick(); tick(); rst = 1'b0; #1;
    chk("rh_post0_d", o_d, 4'b0000);
    tick(); #1;
    chk("rh_post1_d", o_d, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
